// File: rtl/instruction_mem.sv
// Loadable instruction memory for the fetch stage: program is written in LOAD,
// fetched synchronously in RUN; unwritten or out-of-range entries read as halt.
module instruction_mem #(
  parameter int unsigned     INST_W  = 9,
  parameter int unsigned     OP_W    = 5,
  parameter int unsigned     ADDR_W  = 16,
  parameter int unsigned     DEPTH   = 64,
  parameter logic [OP_W-1:0] HALT_OP = 5'b11010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [INST_W-1:0] load_data,
  input  logic              start,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] instruction,
  output logic              inst_valid,
  output logic              halted,
  output logic              load_err,
  output logic              running
);

  localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [INST_W-1:0] HALT_WORD = {HALT_OP, {(INST_W-OP_W){1'b0}}};
  // One extra bit so DEPTH = 2^ADDR_W is still representable in the range test.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t state_q, state_d;

  logic [INST_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  logic              load_ok;
  logic              pc_ok;
  logic [IDX_W-1:0]  load_idx;
  logic [IDX_W-1:0]  pc_idx;
  logic [INST_W-1:0] fetch_word;

  assign load_idx = load_addr[IDX_W-1:0];
  assign pc_idx   = pc[IDX_W-1:0];
  assign load_ok  = (state_q == ST_LOAD) && load_en && ({1'b0, load_addr} < DEPTH_X);
  assign pc_ok    = {1'b0, pc} < DEPTH_X;
  assign running  = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    if (state_q == ST_LOAD && start) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    fetch_word = HALT_WORD;
    if (pc_ok && written[pc_idx]) begin
      fetch_word = mem[pc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Array contents are never reset; the written map masks stale data.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      written     <= '0;
      instruction <= HALT_WORD;
      inst_valid  <= 1'b0;
      halted      <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      if (load_ok) begin
        written[load_idx] <= 1'b1;
      end
      if (load_en && !load_ok) begin
        load_err <= 1'b1;
      end
      if (fetch_en) begin
        if (state_q == ST_RUN) begin
          instruction <= fetch_word;
          inst_valid  <= 1'b1;
          if (fetch_word[INST_W-1 -: OP_W] == HALT_OP) begin
            halted <= 1'b1;
          end
        end else begin
          instruction <= HALT_WORD;
          inst_valid  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_mem.sv
// Bench for instruction_mem: default instance plus a widened instance share one
// stimulus stream and are both compared every cycle against an array-based model.
module tb_instruction_mem;

  logic        clk = 1'b0;
  logic        rst, load_en, start, fetch_en;
  logic [15:0] load_addr, load_data, pc;

  logic [8:0]  instruction0;
  logic        inst_valid0, halted0, load_err0, running0;
  logic [15:0] instruction1;
  logic        inst_valid1, halted1, load_err1, running1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  instruction_mem dut0 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data[8:0]), .start(start), .fetch_en(fetch_en), .pc(pc),
    .instruction(instruction0), .inst_valid(inst_valid0), .halted(halted0),
    .load_err(load_err0), .running(running0)
  );

  instruction_mem #(
    .INST_W(16), .OP_W(6), .ADDR_W(16), .DEPTH(256), .HALT_OP(6'h3F)
  ) dut1 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .fetch_en(fetch_en), .pc(pc),
    .instruction(instruction1), .inst_valid(inst_valid1), .halted(halted1),
    .load_err(load_err1), .running(running1)
  );

  // Reference model: per-instance geometry, array, written map, outputs.
  int unsigned DEP [2] = '{64, 256};
  int unsigned W   [2] = '{9, 16};
  int unsigned OPW [2] = '{5, 6};
  int unsigned HOP [2] = '{26, 63};

  logic [15:0] m_mem  [2][256];
  bit          m_wr   [2][256];
  logic [15:0] m_inst [2];
  bit          m_valid[2], m_halt[2], m_err[2];
  bit          m_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] halt_word(input int k);
    return 16'(HOP[k] << (W[k] - OPW[k]));
  endfunction

  task automatic model_edge();
    logic [15:0] v;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int a = 0; a < 256; a++) m_wr[k][a] = 1'b0;
        m_inst[k]  = halt_word(k);
        m_valid[k] = 1'b0;
        m_halt[k]  = 1'b0;
        m_err[k]   = 1'b0;
      end else begin
        if (fetch_en) begin
          if (m_run) begin
            v = halt_word(k);
            if (int'(pc) < int'(DEP[k]) && m_wr[k][pc])
              v = m_mem[k][pc];
            m_inst[k]  = v;
            m_valid[k] = 1'b1;
            if (int'(v >> (W[k] - OPW[k])) == int'(HOP[k])) m_halt[k] = 1'b1;
          end else begin
            m_inst[k]  = halt_word(k);
            m_valid[k] = 1'b0;
          end
        end
        if (load_en) begin
          if (!m_run && int'(load_addr) < int'(DEP[k])) begin
            m_mem[k][load_addr] = 16'(32'(load_data) & ((32'd1 << W[k]) - 1));
            m_wr[k][load_addr]  = 1'b1;
          end else begin
            m_err[k] = 1'b1;
          end
        end
      end
    end
    if (rst) m_run = 1'b0;
    else if (start) m_run = 1'b1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("inst0",  32'(instruction0), 32'(m_inst[0]));
    check("valid0", 32'(inst_valid0),  32'(m_valid[0]));
    check("halt0",  32'(halted0),      32'(m_halt[0]));
    check("err0",   32'(load_err0),    32'(m_err[0]));
    check("run0",   32'(running0),     32'(m_run));
    check("inst1",  32'(instruction1), 32'(m_inst[1]));
    check("valid1", 32'(inst_valid1),  32'(m_valid[1]));
    check("halt1",  32'(halted1),      32'(m_halt[1]));
    check("err1",   32'(load_err1),    32'(m_err[1]));
    check("run1",   32'(running1),     32'(m_run));
  endtask

  task automatic idle();
    rst = 0; load_en = 0; start = 0; fetch_en = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    idle(); load_en = 1; load_addr = a; load_data = d; step(); load_en = 0;
  endtask

  task automatic fetch(input logic [15:0] a);
    idle(); fetch_en = 1; pc = a; step();
  endtask

  task automatic pulse_start();
    idle(); start = 1; step(); start = 0;
  endtask

  function automatic logic [15:0] pick_addr();
    logic [15:0] edges [6] = '{16'd0, 16'd63, 16'd64, 16'd255, 16'd256, 16'hFFFF};
    if ($urandom_range(0, 7) == 0) return edges[$urandom_range(0, 5)];
    return 16'($urandom_range(0, 270));
  endfunction

  task automatic rand_cycle(input bit in_run);
    rst       = ($urandom_range(0, 99) == 0);
    load_en   = in_run ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
    start     = in_run ? ($urandom_range(0, 9) == 0) : 1'b0;
    fetch_en  = ($urandom_range(0, 3) != 0);
    load_addr = pick_addr();
    pc        = pick_addr();
    load_data = 16'($urandom);
    if ($urandom_range(0, 5) == 0) load_data[8:4] = 5'h1A;
    if ($urandom_range(0, 5) == 0) load_data[15:10] = 6'h3F;
    step();
  endtask

  initial begin
    load_addr = '0; load_data = '0; pc = '0;
    idle();

    do_reset();
    check("rst_inst0", 32'(instruction0), 32'h1A0);
    check("rst_inst1", 32'(instruction1), 32'hFC00);
    check("rst_run0",  32'(running0), 32'd0);

    // Basic load and fetch; the wide instance sees the same program.
    load(16'd1, 16'h0060);
    load(16'd2, 16'h0090);
    pulse_start();
    fetch(16'd1);
    check("basic_f1", 32'(instruction0), 32'h060);
    check("basic_v1", 32'(inst_valid0), 32'd1);
    fetch(16'd2);
    check("basic_f2", 32'(instruction0), 32'h090);
    check("basic_h2", 32'(halted0), 32'd0);
    fetch(16'd3);
    check("basic_f3", 32'(instruction0), 32'h1A0);
    check("basic_h3", 32'(halted0), 32'd1);
    check("sweep_f3", 32'(instruction1), 32'hFC00);
    check("sweep_h3", 32'(halted1), 32'd1);

    // Stall holds the previous fetch.
    fetch(16'd1);
    for (int i = 0; i < 3; i++) begin
      idle(); pc = 16'd2; step();
      check("stall_inst", 32'(instruction0), 32'h060);
      check("stall_vld",  32'(inst_valid0), 32'd1);
    end

    // Load errors: out of range in LOAD, any load in RUN.
    do_reset();
    load(16'd64, 16'h0055);
    check("err_oor", 32'(load_err0), 32'd1);
    check("err_oor_wide", 32'(load_err1), 32'd0);
    pulse_start();
    load(16'd5, 16'h00AB);
    check("err_run", 32'(load_err1), 32'd1);
    fetch(16'd5);
    check("err_f5", 32'(instruction0), 32'h1A0);
    fetch(16'd64);
    check("err_f64", 32'(instruction0), 32'h1A0);

    // Fetch in LOAD, then start together with a load.
    do_reset();
    fetch(16'd0);
    check("ld_fetch", 32'(instruction0), 32'h1A0);
    check("ld_vld",   32'(inst_valid0), 32'd0);
    idle(); start = 1; load_en = 1; load_addr = 16'd0; load_data = 16'h0131; step();
    fetch(16'd0);
    check("comb_f0",  32'(instruction0), 32'h131);
    check("comb_run", 32'(running0), 32'd1);

    // Reset in the middle of back-to-back fetches clears map and flags.
    fetch(16'd1);
    fetch(16'd0);
    idle(); rst = 1; fetch_en = 1; pc = 16'd0; step(); rst = 0;
    check("mid_inst", 32'(instruction0), 32'h1A0);
    check("mid_vld",  32'(inst_valid0), 32'd0);
    check("mid_run",  32'(running0), 32'd0);
    check("mid_halt", 32'(halted0), 32'd0);
    pulse_start();
    fetch(16'd1);
    check("mid_f1", 32'(instruction0), 32'h1A0);
    fetch(16'd0);
    check("mid_f0", 32'(instruction0), 32'h1A0);

    // Randomized episodes: load phase, start, run phase (with occasional reset).
    for (int ep = 0; ep < 16; ep++) begin
      do_reset();
      for (int i = 0, n = $urandom_range(5, 80); i < n; i++) rand_cycle(1'b0);
      idle(); start = 1; load_en = $urandom_range(0, 1); load_addr = pick_addr();
      load_data = 16'($urandom); step();
      for (int i = 0, n = $urandom_range(20, 100); i < n; i++) rand_cycle(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_mem.md
# instruction_mem

Parametrised, loadable instruction memory for the pipelined CPU fetch stage, and the successor to the fixed, combinational instruction ROM. Instruction width, opcode field, PC width and depth are parameters, so new programs are loaded at run time through a write port instead of being compiled in. Reads are synchronous with a stall input. Unwritten or out-of-range locations decode as `halt`, and the block reports when a `halt` has been fetched.

## Interface
- `INST_W`, 9, instruction width in bits
- `OP_W`, 5, opcode field width (opcode occupies bits `[INST_W-1 -: OP_W]`)
- `ADDR_W`, 16, PC / load address width
- `DEPTH`, 64, number of instruction entries (1..2^ADDR_W)
- `HALT_OP`, 5'b11010, opcode returned for unwritten or out-of-range fetches

Ports:
- `clk`  in  1  single clock; everything is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `load_en`  in  1  write strobe for program load
- `load_addr`  in  `ADDR_W`  entry to write
- `load_data`  in  `INST_W`  instruction to write
- `start`  in  1  one-cycle pulse that ends loading and enters RUN
- `fetch_en`  in  1  fetch this cycle; 0 = stall
- `pc`  in  `ADDR_W`  fetch address
- `instruction`  out  `INST_W`  registered fetched instruction
- `inst_valid`  out  1  `instruction` holds a real fetch made in RUN
- `halted`  out  1  sticky; set when a `HALT_OP` instruction has been fetched in RUN
- `load_err`  out  1  sticky; set when a load was rejected
- `running`  out  1  state is RUN

## Operation
- **States.** Two states: LOAD (entered on reset) and RUN.
  - LOAD → RUN on `start`=1.
  - RUN has no exit except `rst`.
- **Storage.** `DEPTH` × `INST_W` array, plus a `DEPTH`-bit written map.
  - `rst` clears the written map. Array contents are not reset; they are masked by the map.
- **Load** (LOAD state, `load_en`=1):
  - If `load_addr` < `DEPTH`: the array entry is written and its map bit is set. Rewriting an entry overwrites it.
  - If `load_addr` ≥ `DEPTH`: the write is dropped and `load_err` is set.
- **Load in RUN.** `load_en`=1 in RUN: the write is dropped, `load_err` is set, and the array is unchanged.
- **`start` + `load_en` in the same cycle** (in LOAD): the write completes, then the state moves to RUN. `start` in RUN is ignored.
- **Fetch** (`fetch_en`=1), with halt word H = {`HALT_OP`, zeros}:
  - In RUN: `instruction` ← array[`pc`] if `pc` < `DEPTH` and the map bit is set; otherwise H. `inst_valid` ← 1.
  - In LOAD: `instruction` ← H, `inst_valid` ← 0.
- **Halt detection.** If a RUN fetch loads an instruction whose opcode equals `HALT_OP`, `halted` ← 1 on the same edge. Synthesised halts (unwritten or out of range) count as `HALT_OP` fetches.
  - Once `halted`=1, further fetches still occur normally; `halted` stays 1 until `rst`.
- **Stall.** `fetch_en`=0 leaves `instruction` and `inst_valid` unchanged. `pc` is ignored.
- **Address handling.** `pc` is compared at full `ADDR_W` width with no truncation or wrap; `pc`=`DEPTH` is out of range.

## Timing
- **Read latency.** 1 cycle: `pc` sampled at edge N appears on `instruction` after edge N.
- **Throughput.** One fetch per cycle, back-to-back.
- **Write-to-read.** A load at edge N is visible to any RUN fetch after it. RUN fetches cannot occur before the `start` edge, so read-during-write never happens.
- **Reset values** (on the first edge with `rst`=1):
  - `instruction` = H (9'h1A0 at defaults)
  - `inst_valid` = 0, `halted` = 0, `load_err` = 0, `running` = 0
  - state = LOAD, written map = 0
- **Reset mid-RUN.** Reset returns to LOAD. All entries read as H until reloaded, and sticky flags clear.
- **`running` timing.** `running` rises on the edge after the `start` sample.
- **Flag timing.** `load_err` and `halted` rise on the edge that samples the offending cycle.

## Test plan
- **Basic load and fetch.** Reset, load addr1 = 9'h060 and addr2 = 9'h090, pulse `start`, fetch `pc`=1,2,3 back-to-back.
  - Required: `instruction` = 9'h060, 9'h090, 9'h1A0 on consecutive cycles.
  - Required: `inst_valid`=1 throughout; `halted` rises with the third fetch.
- **Stall.** Same program as above, fetch `pc`=1, then `fetch_en`=0 for 3 cycles with `pc`=2.
  - Required: `instruction` holds 9'h060 and `inst_valid` holds 1 for all 3 stalled cycles.
- **Load errors.** Write `load_addr`=64 in LOAD; later, in RUN, write addr5 = 9'h0AB.
  - Required: `load_err`=1 after the first write.
  - Required: fetch of `pc`=5 returns 9'h1A0, and `pc`=64 returns 9'h1A0.
- **Fetch in LOAD and combined start/load.** Fetch in LOAD → 9'h1A0 with `inst_valid`=0. Then `start` + `load_en` (addr0 = 9'h131) in the same cycle, then fetch `pc`=0.
  - Required: `instruction` = 9'h131 and `running`=1.
- **Reset mid-RUN.** Assert `rst` during back-to-back RUN fetches.
  - Required: next cycle shows `instruction`=9'h1A0, `inst_valid`=0, `running`=0, all flags 0.
  - Required: after a new `start`, fetch `pc`=1 returns 9'h1A0 because the map was cleared.
- **Parameter sweep.** Re-run the basic load-and-fetch case with `INST_W`=16, `OP_W`=6, `DEPTH`=256, `HALT_OP`=6'h3F.
  - Required: unwritten entry returns 16'hFC00 and `halted` asserts.
